barrel_sprite_ctrl: RTL and testbench
=====================================

BARREL_SPRITE_CTRL -- requirements
Module: barrel_sprite_ctrl

Interface
REQ-001 SHALL have parameter SPAWN_X, default 10'd0: barrel x on spawn.
REQ-002 SHALL have parameter SPAWN_Y, default 10'd100: barrel y on spawn (top-left corner).
REQ-003 SHALL have parameter SPEED, default 2: pixels moved per frame, legal range 1..15.
REQ-004 SHALL have parameter ANIM_DIV, default 4: frames per animation step, legal range 1..8.
REQ-005 SHALL have port Clk, input, 1: single clock for all logic.
REQ-006 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port frame_start, input, 1: one-cycle pulse per video frame.
REQ-008 SHALL have port spawn, input, 1: one-cycle request to launch a barrel.
REQ-009 SHALL have ports DrawX and DrawY, input, 10 each: current VGA pixel, valid range 0..639 and 0..479.
REQ-010 SHALL have port rom_data, input, 24: RGB returned by the barrel ROM one cycle after rom_addr.
REQ-011 SHALL have port rom_addr, output, 14: barrel ROM read address.
REQ-012 SHALL have ports barrel_x and barrel_y, output, 10 each: current barrel position.
REQ-013 SHALL have port active, output, 1: barrel is on screen.
REQ-014 SHALL have ports pixel_valid (output, 1) and pixel_rgb (output, 24): opaque barrel pixel for the DrawX/DrawY presented 2 cycles earlier.

Function
REQ-015 Sprite geometry SHALL be 20 wide x 21 tall, with 4 animation frames stored consecutively (420 words each, 1680 total).
REQ-016 FSM states SHALL be IDLE and ROLL (plus RETURN when BARREL_BOUNCE_EN is defined); active = (state != IDLE).
REQ-017 In IDLE, spawn SHALL load x=SPAWN_X, y=SPAWN_Y, anim=0, div=0 and enter ROLL; frame_start in the same cycle SHALL cause no motion.
REQ-018 In ROLL, spawn SHALL be ignored.
REQ-019 On frame_start in ROLL, x SHALL become x+SPEED, computed 11 bits wide; if the sum >= 640 the FSM SHALL enter IDLE and x SHALL hold.
REQ-020 On each frame_start in ROLL, div SHALL increment; when div reaches ANIM_DIV-1 it SHALL clear to 0 and anim SHALL advance modulo 4 (3->0).
REQ-021 hit SHALL be active && x<=DrawX<=x+19 && y<=DrawY<=y+20; comparisons SHALL use 11 bits so that no wrap occurs near 639.
REQ-022 rom_addr SHALL be combinational: anim*420 + (DrawY-y)*20 + (DrawX-x), built with shift-add (no generic multiplier); rom_addr SHALL be 0 when hit=0.
REQ-023 Stage 1: hit SHALL be registered to hit_d, aligned with rom_data.
REQ-024 Stage 2: pixel_valid SHALL register hit_d && (rom_data != 24'hffffff); pixel_rgb SHALL register rom_data.
REQ-025 Total latency SHALL be 2 cycles from DrawX/DrawY to pixel_valid/pixel_rgb, with throughput of 1 pixel per clock.
REQ-026 Position and animation updates SHALL occur only on frame_start, so the sprite never tears mid-frame provided frame_start coincides with vertical blank.

Reset
REQ-027 Asserting Reset_n low SHALL immediately force state=IDLE, x=0, y=0, anim=0, div=0, hit_d=0, pixel_valid=0 and pixel_rgb=0 (active=0).
REQ-028 Reset during ROLL SHALL abort the barrel; after release, a new spawn SHALL be required.

Configuration
REQ-029 When BARREL_BOUNCE_EN is defined: in ROLL, a sum x+SPEED > 620 SHALL clamp x to 620 and enter RETURN.
REQ-030 In RETURN, x SHALL decrease by SPEED per frame_start; if x < SPEED the FSM SHALL enter IDLE.
REQ-031 In RETURN, anim SHALL decrement modulo 4 (0->3).
REQ-032 When BARREL_BOUNCE_EN is undefined, RETURN SHALL not exist and REQ-019 SHALL govern exit.

Structure
REQ-033 Package barrel_pkg SHALL hold: SPR_W=20, SPR_H=21, SPR_FRAMES=4, FRAME_WORDS=420, SCREEN_W=640, TRANSPARENT_RGB=24'hffffff, and the state enum type.
REQ-034 A sub-module barrel_addr_gen (combinational hit and rom_addr) is natural; the FSM and pipeline SHALL remain in the top module.

Verification
REQ-035 Reset, then spawn, then no frame_start: expect barrel_x=0, barrel_y=100, active=1; DrawX=5, DrawY=102 -> rom_addr=45.
REQ-036 After 8 frame_starts: expect barrel_x=16 and anim=2; DrawX=16, DrawY=100 -> rom_addr=840.
REQ-037 Model ROM returns ffffff at address 45: pixel_valid=0; any other value -> pixel_valid=1 exactly 2 cycles later, pixel_rgb equal to that value.
REQ-038 Barrel at x=638 with SPEED=2, then frame_start -> IDLE, active=0, pixel_valid stays 0 (undefined macro); with macro defined -> x=620 in RETURN.
REQ-039 spawn and frame_start in the same cycle -> barrel_x=SPAWN_X; spawn during ROLL -> position unchanged.
REQ-040 Reset_n low mid-ROLL -> all outputs 0 within the same cycle, asynchronously.

Source files
------------

// File: rtl/barrel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barrel_pkg
// Description : Shared constants and state type for the rolling barrel
//               sprite controller. Build macro BARREL_BOUNCE_EN adds the
//               RETURN state.
// Revision    : 1.0 - initial release
// ============================================================================
package barrel_pkg;

    // Sprite geometry and ROM layout
    localparam int SPR_W       = 20;
    localparam int SPR_H       = 21;
    localparam int SPR_FRAMES  = 4;
    localparam int FRAME_WORDS = 420;

    // Visible screen width in pixels
    localparam int SCREEN_W    = 640;

    // ROM colour that marks a see-through sprite pixel
    localparam logic [23:0] TRANSPARENT_RGB = 24'hffffff;

`ifdef BARREL_BOUNCE_EN
    // Right-hand turnaround column for the bouncing barrel
    localparam int BOUNCE_X_MAX = 620;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROLL   = 2'd1,
        ST_RETURN = 2'd2
    } barrel_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROLL   = 2'd1
    } barrel_state_e;
`endif

endpackage : barrel_pkg
`default_nettype wire

// File: rtl/barrel_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : barrel_addr_gen
// Description : Combinational sprite hit test and barrel ROM address
//               generation (anim*420 + dy*20 + dx) using shift-add only.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_addr_gen
    import barrel_pkg::*;
(
    input  logic        active_i,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [1:0]  anim_i,
    input  logic [9:0]  draw_x_i,
    input  logic [9:0]  draw_y_i,
    output logic        hit_o,
    output logic [13:0] rom_addr_o
);

    // Bounding box edges, 11 bits wide so x+19 near column 639 cannot wrap
    logic [10:0] w_x_lo;
    logic [10:0] w_x_hi;
    logic [10:0] w_y_lo;
    logic [10:0] w_y_hi;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [13:0] w_anim_ext;
    logic [13:0] w_dy_ext;
    logic [13:0] w_anim_off;
    logic [13:0] w_row_off;
    logic [13:0] w_addr_sum;

    assign w_x_lo = {1'b0, x_i};
    assign w_x_hi = {1'b0, x_i} + 11'(SPR_W - 1);
    assign w_y_lo = {1'b0, y_i};
    assign w_y_hi = {1'b0, y_i} + 11'(SPR_H - 1);

    // Pixel lies inside the 20x21 sprite rectangle of an on-screen barrel
    assign hit_o = active_i
                 && ({1'b0, draw_x_i} >= w_x_lo) && ({1'b0, draw_x_i} <= w_x_hi)
                 && ({1'b0, draw_y_i} >= w_y_lo) && ({1'b0, draw_y_i} <= w_y_hi);

    // Offsets inside the sprite; only meaningful while hit_o is high
    assign w_dx = {1'b0, draw_x_i} - w_x_lo;
    assign w_dy = {1'b0, draw_y_i} - w_y_lo;

    assign w_anim_ext = {12'd0, anim_i};
    assign w_dy_ext   = {3'd0, w_dy};

    // 420 = 256 + 128 + 32 + 4 ; 20 = 16 + 4
    assign w_anim_off = (w_anim_ext << 8) + (w_anim_ext << 7)
                      + (w_anim_ext << 5) + (w_anim_ext << 2);
    assign w_row_off  = (w_dy_ext << 4) + (w_dy_ext << 2);
    assign w_addr_sum = w_anim_off + w_row_off + {3'd0, w_dx};

    // Address is forced to zero off-sprite so the ROM bus stays quiet
    assign rom_addr_o = hit_o ? w_addr_sum : 14'd0;

endmodule : barrel_addr_gen
`default_nettype wire

// File: rtl/barrel_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : barrel_sprite_ctrl
// Description : Rolling barrel sprite. Frame-synchronous motion and
//               animation FSM plus a two-stage pixel pipeline that looks the
//               sprite up in an external synchronous ROM.
//               Optional build macro: BARREL_BOUNCE_EN (clamp at x=620 and
//               roll back left in a RETURN state).
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_sprite_ctrl
    import barrel_pkg::*;
#(
    parameter logic [9:0] SPAWN_X  = 10'd0,
    parameter logic [9:0] SPAWN_Y  = 10'd100,
    parameter int         SPEED    = 2,
    parameter int         ANIM_DIV = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        spawn,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [23:0] rom_data,
    output logic [13:0] rom_addr,
    output logic [9:0]  barrel_x,
    output logic [9:0]  barrel_y,
    output logic        active,
    output logic        pixel_valid,
    output logic [23:0] pixel_rgb
);

    // Step size in both widths used by the position arithmetic
    localparam logic [10:0] SPEED_W  = 11'(SPEED);
    localparam logic [9:0]  SPEED_X  = 10'(SPEED);
    // Divider value on which the animation frame advances
    localparam logic [2:0]  DIV_LAST = 3'(ANIM_DIV - 1);

    barrel_state_e state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    anim_q, anim_d;
    logic [2:0]    div_q, div_d;

    logic          hit_dly_q;
    logic          pixel_valid_q;
    logic [23:0]   pixel_rgb_q;

    logic          w_hit;
    logic [10:0]   w_sum_fwd;
    logic          w_div_wrap;
    logic [2:0]    w_div_next;

    assign active     = (state_q != ST_IDLE);
    assign barrel_x   = x_q;
    assign barrel_y   = y_q;
    assign w_sum_fwd  = {1'b0, x_q} + SPEED_W;
    assign w_div_wrap = (div_q == DIV_LAST);
    assign w_div_next = w_div_wrap ? 3'd0 : (div_q + 3'd1);

    // State, position and animation registers; reset aborts any barrel
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            anim_q  <= 2'd0;
            div_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            anim_q  <= anim_d;
            div_q   <= div_d;
        end
    end

    // Next-state logic: movement only ever happens on frame_start
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        anim_d  = anim_q;
        div_d   = div_q;

        case (state_q)
            ST_IDLE: begin
                // A spawn cycle only loads; a coincident frame_start is ignored
                if (spawn) begin
                    state_d = ST_ROLL;
                    x_d     = SPAWN_X;
                    y_d     = SPAWN_Y;
                    anim_d  = 2'd0;
                    div_d   = 3'd0;
                end
            end

            ST_ROLL: begin
                if (frame_start) begin
`ifdef BARREL_BOUNCE_EN
                    if (w_sum_fwd > 11'(BOUNCE_X_MAX)) begin
                        state_d = ST_RETURN;
                        x_d     = 10'(BOUNCE_X_MAX);
                        div_d   = w_div_next;
                        anim_d  = w_div_wrap ? (anim_q + 2'd1) : anim_q;
                    end else
`endif
                    if (w_sum_fwd >= 11'(SCREEN_W)) begin
                        // Barrel has left the screen; position is frozen
                        state_d = ST_IDLE;
                    end else begin
                        x_d    = w_sum_fwd[9:0];
                        div_d  = w_div_next;
                        anim_d = w_div_wrap ? (anim_q + 2'd1) : anim_q;
                    end
                end
            end

`ifdef BARREL_BOUNCE_EN
            ST_RETURN: begin
                if (frame_start) begin
                    if (x_q < SPEED_X) begin
                        state_d = ST_IDLE;
                    end else begin
                        x_d    = x_q - SPEED_X;
                        div_d  = w_div_next;
                        // Rolling left spins the barrel backwards
                        anim_d = w_div_wrap ? (anim_q - 2'd1) : anim_q;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    barrel_addr_gen u_addr_gen (
        .active_i   (active),
        .x_i        (x_q),
        .y_i        (y_q),
        .anim_i     (anim_q),
        .draw_x_i   (DrawX),
        .draw_y_i   (DrawY),
        .hit_o      (w_hit),
        .rom_addr_o (rom_addr)
    );

    // Pixel pipeline: stage 1 aligns hit with rom_data, stage 2 drops
    // transparent texels and registers the colour
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_dly_q     <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_rgb_q   <= 24'd0;
        end else begin
            hit_dly_q     <= w_hit;
            pixel_valid_q <= hit_dly_q && (rom_data != TRANSPARENT_RGB);
            pixel_rgb_q   <= rom_data;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_rgb   = pixel_rgb_q;

endmodule : barrel_sprite_ctrl
`default_nettype wire

// File: tb/tb_barrel_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_sprite_ctrl
// Description : Self-checking bench for barrel_sprite_ctrl: a behavioural
//               barrel model, a table of address vectors and a scoreboard
//               queue for the two-cycle pixel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_sprite_ctrl;

    localparam int TB_SPEED = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        spawn = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [23:0] rom_data = 24'd0;
    logic [13:0] rom_addr;
    logic [9:0]  barrel_x;
    logic [9:0]  barrel_y;
    logic        active;
    logic        pixel_valid;
    logic [23:0] pixel_rgb;

    barrel_sprite_ctrl #(
        .SPAWN_X  (10'd0),
        .SPAWN_Y  (10'd100),
        .SPEED    (TB_SPEED),
        .ANIM_DIV (4)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .spawn       (spawn),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .barrel_x    (barrel_x),
        .barrel_y    (barrel_y),
        .active      (active),
        .pixel_valid (pixel_valid),
        .pixel_rgb   (pixel_rgb)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM model: word 45 is transparent, every other word distinct
    function automatic logic [23:0] rom_fn(input logic [13:0] a);
        if (a == 14'd45) return 24'hffffff;
        return 24'h120000 + {10'd0, a};
    endfunction

    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural barrel model ----------------
    bit m_active = 0;
    bit m_ret = 0;
    int m_x = 0, m_y = 0, m_anim = 0, m_div = 0;

    function automatic void m_adv(input int dir);
        if (m_div == 3) begin
            m_div  = 0;
            m_anim = (m_anim + dir + 4) % 4;
        end else begin
            m_div++;
        end
    endfunction

    function automatic void m_frame();
        int sum;
        if (!m_active) return;
        if (!m_ret) begin
            sum = m_x + TB_SPEED;
`ifdef BARREL_BOUNCE_EN
            if (sum > 620) begin
                m_x = 620; m_ret = 1; m_adv(1);
            end else
`endif
            if (sum >= 640) m_active = 0;
            else begin m_x = sum; m_adv(1); end
        end else begin
            if (m_x < TB_SPEED) begin m_active = 0; m_ret = 0; end
            else begin m_x -= TB_SPEED; m_adv(-1); end
        end
    endfunction

    function automatic bit m_hit(input int dx, input int dy);
        return m_active && dx >= m_x && dx <= m_x + 19 && dy >= m_y && dy <= m_y + 20;
    endfunction

    function automatic logic [13:0] m_addr(input int dx, input int dy);
        if (!m_hit(dx, dy)) return 14'd0;
        return 14'(m_anim * 420 + (dy - m_y) * 20 + (dx - m_x));
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct { bit v; logic [23:0] rgb; } exp_t;
    exp_t sbq[$];
    bit   drv_flag = 0;

    initial begin : monitor
        bit f;
        bit p1;
        exp_t e;
        p1 = 0;
        forever begin
            @(posedge Clk);
            f = drv_flag;
            #2;
            if (p1) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow: actual=empty required=entry");
                end else begin
                    e = sbq.pop_front();
                    check("pixel_valid", pixel_valid, e.v);
                    check("pixel_rgb", pixel_rgb, e.rgb);
                end
            end
            p1 = f;
        end
    end

    // Drive one pixel coordinate; exp_addr < 0 skips the address check
    task automatic drive_pix(input int dx, input int dy, input int exp_addr);
        exp_t e;
        logic [23:0] r;
        DrawX    = 10'(dx);
        DrawY    = 10'(dy);
        drv_flag = 1;
        r        = rom_fn(m_addr(dx, dy));
        e.v      = m_hit(dx, dy) && (r != 24'hffffff);
        e.rgb    = r;
        sbq.push_back(e);
        #1;
        if (exp_addr >= 0) check("rom_addr", rom_addr, exp_addr);
        @(posedge Clk); #1;
    endtask

    task automatic drain();
        drv_flag = 0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic do_frame();
        frame_start = 1;
        m_frame();
        @(posedge Clk); #1;
        frame_start = 0;
    endtask

    task automatic do_spawn(input bit with_frame);
        spawn       = 1;
        frame_start = with_frame;
        if (!m_active) begin
            m_active = 1; m_ret = 0;
            m_x = 0; m_y = 100; m_anim = 0; m_div = 0;
        end else if (with_frame) begin
            m_frame();
        end
        @(posedge Clk); #1;
        spawn       = 0;
        frame_start = 0;
    endtask

    typedef struct { int dx; int dy; int addr; } vec_t;
    vec_t vecs[8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        // Barrel parked at (0,100), animation frame 0
        vecs[0] = '{5,   102, 45};
        vecs[1] = '{0,   100, 0};
        vecs[2] = '{19,  100, 19};
        vecs[3] = '{20,  100, 0};
        vecs[4] = '{0,   120, 400};
        vecs[5] = '{0,   121, 0};
        vecs[6] = '{19,  120, 419};
        vecs[7] = '{3,   99,  0};

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_x", barrel_x, 0);
        check("rst_y", barrel_y, 0);
        check("rst_active", active, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_rgb", pixel_rgb, 0);
        Reset_n = 1;
        @(posedge Clk); #1;

        // Spawn with coincident frame_start: no motion
        do_spawn(1);
        check("spawn_x", barrel_x, 0);
        check("spawn_y", barrel_y, 100);
        check("spawn_active", active, 1);

        for (int i = 0; i < 8; i++) drive_pix(vecs[i].dx, vecs[i].dy, vecs[i].addr);
        drain();

        // Spawn while rolling is ignored
        do_spawn(0);
        check("respawn_x", barrel_x, 0);
        check("respawn_y", barrel_y, 100);

        // Eight frames: x=16, animation frame 2
        repeat (8) do_frame();
        check("roll8_x", barrel_x, 16);
        drive_pix(16, 100, 840);
        drive_pix(35, 120, 1259);
        drive_pix(36, 100, 0);
        drain();

        // Roll toward the right edge
        n = 0;
        while (m_active && m_x != 638 && n < 400) begin do_frame(); n++; end
        check("edge_x", barrel_x, m_x);
        check("edge_active", active, m_active);
        do_frame();
        check("exit_active", active, m_active);
        check("exit_x", barrel_x, m_x);
        drive_pix(638, 100, -1);
        drive_pix(639, 110, -1);
        drain();

        // Asynchronous reset in the middle of a roll
        do_spawn(0);
        repeat (3) do_frame();
        DrawX = 10'(m_x + 1);
        DrawY = 10'd101;
        repeat (3) @(posedge Clk);
        #1;
        check("pre_rst_valid", pixel_valid, 1);
        #3;
        Reset_n = 0;
        m_active = 0; m_ret = 0; m_x = 0; m_y = 0; m_anim = 0; m_div = 0;
        #1;
        check("arst_active", active, 0);
        check("arst_x", barrel_x, 0);
        check("arst_y", barrel_y, 0);
        check("arst_valid", pixel_valid, 0);
        check("arst_rgb", pixel_rgb, 0);
        check("arst_addr", rom_addr, 0);
        @(posedge Clk); #1;
        Reset_n = 1;
        do_frame();
        check("post_rst_active", active, 0);

        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_barrel_sprite_ctrl
`default_nettype wire
